rate_limited_rr_arbiter: RTL

Shares one token-bucket-limited downstream resource between N requesters. It runs round-robin arbitration, holds each grant until the resource signals completion, and charges a fixed token cost per grant against an internal saturating bucket. It sits between the requester ports and the shared resource and is the only block that grants access to it. A hold watchdog releases a stuck grant.

---
 rtl/rl_arb_pkg.sv | 42 ++++
 rtl/rl_bucket_core.sv | 37 +++
 rtl/rate_limited_rr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rl_arb_pkg.sv
// Shared types and helpers for the rate-limited round-robin arbiter.
package rl_arb_pkg;

    localparam int unsigned TOK_W      = 32;
    localparam int unsigned PICK_MAX_N = 32;
    localparam int unsigned PICK_W     = 5;
    localparam int unsigned J_W        = PICK_W + 1;

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    function automatic logic [TOK_W-1:0] sat_add(input logic [TOK_W-1:0] a,
                                                 input logic [TOK_W-1:0] b,
                                                 input logic [TOK_W-1:0] maxv);
        logic [TOK_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, maxv}) ? maxv : sum[TOK_W-1:0];
    endfunction

    // First set bit at or after ptr, wrapping at n (n <= PICK_MAX_N, ptr < n).
    function automatic pick_t rr_pick(input logic [PICK_MAX_N-1:0] req,
                                      input logic [PICK_W-1:0]     ptr,
                                      input int unsigned           n);
        pick_t          p;
        logic [J_W-1:0] j;
        p = '0;
        for (int unsigned i = 0; i < PICK_MAX_N; i++) begin
            j = {1'b0, ptr} + J_W'(i);
            if (j >= J_W'(n)) j = j - J_W'(n);
            if (i < n && !p.found && req[j[PICK_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[PICK_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rl_bucket_core.sv
// Saturating token bucket: accrues RATE_NUM per cycle, charges TOKEN_COST on consume.
module rl_bucket_core
    import rl_arb_pkg::*;
#(
    parameter int unsigned RATE_NUM   = 3,
    parameter int unsigned TOK_MAX    = 128,
    parameter int unsigned TOKEN_COST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume_i,
    output logic [TOK_W-1:0] tokens_o,
    output logic             ready_o
);

    logic [TOK_W-1:0] r_tokens;
    logic [TOK_W-1:0] w_accrued;
    logic [TOK_W-1:0] w_tokens_d;

    // consume_i is only raised while ready_o, so the subtraction cannot underflow.
    always_comb begin
        w_accrued  = sat_add(r_tokens, TOK_W'(RATE_NUM), TOK_W'(TOK_MAX));
        w_tokens_d = consume_i ? (w_accrued - TOK_W'(TOKEN_COST)) : w_accrued;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tokens <= TOK_W'(TOK_MAX);
        end else begin
            r_tokens <= w_tokens_d;
        end
    end

    assign tokens_o = r_tokens;
    assign ready_o  = (r_tokens >= TOK_W'(TOKEN_COST));

endmodule

// File: rtl/rate_limited_rr_arbiter.sv
// Round-robin arbiter for one shared resource, gated by a token bucket,
// with a hold watchdog that reclaims grants never completed by done_i.
module rate_limited_rr_arbiter
    import rl_arb_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DEN        = 16,
    parameter int unsigned RATE_NUM   = 3,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned TOKEN_COST = DEN,
    parameter int unsigned MAX_HOLD   = 16,
    localparam int unsigned IDW       = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned TOK_MAX   = BURST_MAX * DEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             done_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDW-1:0]   gnt_id_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [TOK_W-1:0] tokens_o,
    output logic             timeout_o
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    state_t            r_state, w_state_d;
    logic [N-1:0]      r_gnt, w_gnt_d;
    logic [IDW-1:0]    r_gnt_id, w_gnt_id_d;
    logic [IDW-1:0]    r_rr_ptr, w_rr_ptr_d;
    logic [HOLD_W-1:0] r_hold, w_hold_d;
    logic              r_timeout, w_timeout_d;
    logic              w_ready;
    logic              w_issue;
    logic              w_consume;
    logic              w_hold_expired;
    logic [IDW-1:0]    w_winner;
    pick_t             w_pick;
    logic              w_unused_idx;

    rl_bucket_core #(
        .RATE_NUM   (RATE_NUM),
        .TOK_MAX    (TOK_MAX),
        .TOKEN_COST (TOKEN_COST)
    ) u_bucket (
        .clk       (clk),
        .rst_n     (rst_n),
        .consume_i (w_consume),
        .tokens_o  (tokens_o),
        .ready_o   (w_ready)
    );

    assign w_pick         = rr_pick(PICK_MAX_N'(req_i), PICK_W'(r_rr_ptr), N);
    assign w_winner       = w_pick.idx[IDW-1:0];
    assign w_unused_idx   = ^w_pick.idx;
    assign w_issue        = (r_state == IDLE) && w_pick.found && w_ready;
    assign w_hold_expired = (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_rr_ptr  <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_gnt_id  <= w_gnt_id_d;
            r_rr_ptr  <= w_rr_ptr_d;
            r_hold    <= w_hold_d;
            r_timeout <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_gnt_id_d  = r_gnt_id;
        w_rr_ptr_d  = r_rr_ptr;
        w_hold_d    = r_hold;
        w_timeout_d = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_d          = BUSY;
                    w_gnt_d            = '0;
                    w_gnt_d[w_winner]  = 1'b1;
                    w_gnt_id_d         = w_winner;
                    w_rr_ptr_d         = (w_winner == IDW'(N - 1)) ? '0 : w_winner + IDW'(1);
                    w_hold_d           = '0;
                end
            end
            BUSY: begin
                w_hold_d = r_hold + HOLD_W'(1);
                // done_i wins over a watchdog expiry on the same edge.
                if (done_i) begin
                    w_state_d = IDLE;
                    w_gnt_d   = '0;
                end else if (w_hold_expired) begin
                    w_state_d   = IDLE;
                    w_gnt_d     = '0;
                    w_timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_consume = w_issue;
        busy_o    = (r_state == BUSY);
        gnt_o     = r_gnt;
        gnt_id_o  = r_gnt_id;
        timeout_o = r_timeout;
        ready_o   = w_ready;
    end

endmodule
